// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic Genius player: state encoding,
// LED/button bus width and a one-hot helper.
package jogador_pkg;

  localparam int LED_W = 4;

  localparam logic [3:0] EST_IDLE      = 4'd0;
  localparam logic [3:0] EST_INICIA    = 4'd1;
  localparam logic [3:0] EST_OBSERVA   = 4'd2;
  localparam logic [3:0] EST_LED_ATIVO = 4'd3;
  localparam logic [3:0] EST_PRESS     = 4'd4;
  localparam logic [3:0] EST_SOLTA     = 4'd5;
  localparam logic [3:0] EST_FIM       = 4'd6;

  typedef enum logic [3:0] {
    ST_IDLE      = EST_IDLE,
    ST_INICIA    = EST_INICIA,
    ST_OBSERVA   = EST_OBSERVA,
    ST_LED_ATIVO = EST_LED_ATIVO,
    ST_PRESS     = EST_PRESS,
    ST_SOLTA     = EST_SOLTA,
    ST_FIM       = EST_FIM
  } estado_t;

  // True when exactly one bit of the LED value is set.
  function automatic logic is_one_hot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/jogador_memoria.sv
// Move store for one round: DEPTH entries of one LED value each.
// Synchronous write, asynchronous read; contents are not reset.
module jogador_memoria
  import jogador_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LED_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [LED_W-1:0] rd_data
);

  logic [LED_W-1:0] mem [DEPTH];

  // Capture a shown move into the addressed slot.
  always_ff @(posedge clock) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic Genius player. Records moves shown on leds, then replays them
// as press/release pulses on botoes once the display has been quiet for
// GAP_CYCLES. Optional build macro JOGADOR_ERRO_EN adds erro_idx/erro_en to
// deliberately corrupt one replayed move.
//
// Bus protocol: a move is any nonzero leds value, counted once from its
// first nonzero cycle until leds returns to zero. A button press is a
// nonzero botoes held PRESS_CYCLES, always followed by RELEASE_CYCLES of zero.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int PRESS_CYCLES   = 100,
  parameter int RELEASE_CYCLES = 100,
  parameter int GAP_CYCLES     = 50,
  parameter int INICIAR_CYCLES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ativar,
  input  logic [LED_W-1:0] leds,
  input  logic             pronto,
  input  logic             ganhou,
  input  logic             perdeu,
`ifdef JOGADOR_ERRO_EN
  input  logic [4:0]       erro_idx,
  input  logic             erro_en,
`endif
  output logic             iniciar,
  output logic [LED_W-1:0] botoes,
  output logic [4:0]       rodada,
  output logic             terminou,
  output logic             erro_captura,
  output logic [3:0]       db_estado
);

  localparam int TMAX_A = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int TMAX_B = (GAP_CYCLES > INICIAR_CYCLES) ? GAP_CYCLES : INICIAR_CYCLES;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  estado_t          state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    rodada_q, rodada_d;
  logic             erro_q, erro_d;
  logic             ativar_q;
  logic             iniciar_q, terminou_q;
  logic [LED_W-1:0] botoes_q;
  logic             mem_we;
  logic [LED_W-1:0] mem_rd_data;
  logic [LED_W-1:0] press_val;

  // pronto is informational only; the game outcome comes from ganhou/perdeu.
  logic unused_pronto;
  assign unused_pronto = pronto;

  jogador_memoria #(.DEPTH(DEPTH), .AW(AW)) u_memoria (
    .clock   (clock),
    .we      (mem_we),
    .wr_addr (wptr_q[AW-1:0]),
    .wr_data (leds),
    .rd_addr (rptr_d[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // Next-state, timer, pointer and capture logic; game end overrides all.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rodada_d = rodada_q;
    erro_d   = erro_q;
    mem_we   = 1'b0;
    if (state_q != ST_IDLE && state_q != ST_FIM && (ganhou || perdeu)) begin
      state_d = ST_FIM;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ativar && !ativar_q) begin
            state_d = ST_INICIA;
            timer_d = '0;
            erro_d  = 1'b0;
          end
        end
        ST_INICIA: begin
          if (timer_q == TW'(INICIAR_CYCLES - 1)) begin
            state_d  = ST_OBSERVA;
            timer_d  = '0;
            wptr_d   = '0;
            rodada_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_OBSERVA: begin
          if (leds != '0) begin
            state_d = ST_LED_ATIVO;
            timer_d = '0;
            if (!is_one_hot(leds) || rodada_q == PW'(DEPTH)) begin
              erro_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wptr_d   = wptr_q + 1'b1;
              rodada_d = rodada_q + 1'b1;
            end
          end else if (rodada_q != '0) begin
            if (timer_q == TW'(GAP_CYCLES - 1)) begin
              state_d = ST_PRESS;
              timer_d = '0;
              rptr_d  = '0;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        ST_LED_ATIVO: begin
          if (leds == '0) begin
            state_d = ST_OBSERVA;
            timer_d = '0;
          end
        end
        ST_PRESS: begin
          if (timer_q == TW'(PRESS_CYCLES - 1)) begin
            state_d = ST_SOLTA;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_SOLTA: begin
          if (timer_q == TW'(RELEASE_CYCLES - 1)) begin
            timer_d = '0;
            rptr_d  = rptr_q + 1'b1;
            if (rptr_q + 1'b1 == rodada_q) begin
              state_d  = ST_OBSERVA;
              wptr_d   = '0;
              rodada_d = '0;
            end else begin
              state_d = ST_PRESS;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_FIM: begin
          if (!ativar) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Value to drive for the press being entered (optionally corrupted).
  always_comb begin
    press_val = mem_rd_data;
`ifdef JOGADOR_ERRO_EN
    if (erro_en && rptr_d == PW'(erro_idx)) begin
      press_val = {mem_rd_data[LED_W-2:0], mem_rd_data[LED_W-1]};
    end
`endif
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      rodada_q   <= '0;
      erro_q     <= 1'b0;
      ativar_q   <= 1'b0;
      iniciar_q  <= 1'b0;
      terminou_q <= 1'b0;
      botoes_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rodada_q   <= rodada_d;
      erro_q     <= erro_d;
      ativar_q   <= ativar;
      iniciar_q  <= (state_d == ST_INICIA);
      terminou_q <= (state_d == ST_FIM);
      botoes_q   <= (state_d == ST_PRESS) ? press_val : '0;
    end
  end

  assign iniciar      = iniciar_q;
  assign botoes       = botoes_q;
  assign terminou     = terminou_q;
  assign rodada       = 5'(rodada_q);
  assign erro_captura = erro_q;
  assign db_estado    = state_q;

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player for the Genius memory game: the button-side counterpart of the game's LED output.
- Watches the game's `leds` bus, records each shown move, and once the display goes quiet replays the recorded moves as timed press/release pulses on `botoes`.
- Pulses `iniciar` to start a game and stops on `ganhou`/`perdeu`.
- Sits beside `jogo_desafio_memoria` on the FPGA top and in regression benches, replacing hand-written button stimulus.

Parameters:
- DEPTH, 16, maximum moves stored per round.
- PRESS_CYCLES, 100, clock cycles a button is held.
- RELEASE_CYCLES, 100, clock cycles buttons are zero between presses.
- GAP_CYCLES, 50, idle LED cycles after the last captured move that end the display phase.
- INICIAR_CYCLES, 5, width of the `iniciar` pulse.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ativar  in  1  level; rising edge while in IDLE starts a game.
- leds  in  4  game LED bus; a one-hot value means a move is being shown.
- pronto  in  1  game finished indication.
- ganhou  in  1  game won.
- perdeu  in  1  game lost.
- iniciar  out  1  start pulse to the game.
- botoes  out  4  button drive to the game.
- rodada  out  5  number of moves captured in the current round, 0..DEPTH.
- terminou  out  1  high in FIM.
- erro_captura  out  1  sticky flag: a non-one-hot LED value was seen, or DEPTH was overflowed.
- db_estado  out  4  encoded FSM state.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; iniciar=0, botoes=0, rodada=0, terminou=0, erro_captura=0.
  - Write and read pointers and the timer are cleared; memory contents are don't-care.
- State encoding: IDLE=0, INICIA=1, OBSERVA=2, LED_ATIVO=3, PRESS=4, SOLTA=5, FIM=6.
- IDLE:
  - Registered ativar 0->1 -> INICIA; timer cleared.
  - erro_captura is cleared on leaving IDLE.
- INICIA: iniciar=1 for exactly INICIAR_CYCLES cycles, then -> OBSERVA with wptr=0, rodada=0.
- OBSERVA (botoes=0):
  - leds one-hot -> store leds at mem[wptr], wptr++, rodada++, -> LED_ATIVO. The write happens in the cycle leds is first nonzero.
  - leds nonzero but not one-hot -> set erro_captura, do not store, -> LED_ATIVO.
  - leds==0 and rodada>0 -> timer counts; timer==GAP_CYCLES-1 -> PRESS with rptr=0, timer cleared.
  - rodada==0 -> no timeout; waits indefinitely.
- LED_ATIVO: waits for leds==0, then -> OBSERVA with timer cleared. A held LED therefore counts as one move.
- Overflow: a capture with rodada==DEPTH sets erro_captura and discards the move; rodada saturates at DEPTH.
- PRESS: botoes=mem[rptr] for PRESS_CYCLES cycles -> SOLTA.
- SOLTA: botoes=0 for RELEASE_CYCLES cycles, then rptr++.
  - If rptr reaches rodada -> OBSERVA with wptr=0, rodada=0, since the game re-shows the whole sequence each round.
  - Otherwise -> PRESS.
- Termination: ganhou or perdeu sampled high in any state other than IDLE -> FIM on the next edge; botoes=0 that same edge.
  - This takes priority over every other transition, including a simultaneous LED capture.
  - pronto alone is informational; it is not used for transitions.
- FIM: terminou=1, botoes=0; ativar==0 -> IDLE.
- Outputs are registered: botoes, iniciar and terminou change only on clock edges.
- Widths: the timer is wide enough for the max of all cycle parameters; pointers are clog2(DEPTH)+1 bits.

Optional Feature:
- Macro: JOGADOR_ERRO_EN.
- When defined, the block adds an input `erro_idx` (5 bits) and an input `erro_en` (1 bit). With erro_en=1, the replay at rptr==erro_idx drives the rotated value {mem[rptr][2:0], mem[rptr][3]} instead of mem[rptr], to provoke `perdeu`.
- When undefined, neither port exists and replay is always faithful.

Decomposition:
- Shared package `jogador_pkg`: state encoding localparams and an is_one_hot helper function.
- One natural sub-module, `jogador_memoria`: DEPTH x 4 register file with synchronous write and asynchronous read.
- FSM, timer and pointers stay in the top.

Test Plan:
- Reset asserted mid-PRESS with botoes=0010 -> botoes=0000, db_estado=0 immediately, without waiting for a clock edge.
- ativar 0->1 -> iniciar high for exactly 5 cycles, then db_estado=2, rodada=0.
- Model shows leds 0001 (10 cycles), 0 (5), 0010 (10), then 0 for 50 cycles -> rodada=2. Replay is botoes 0001 for 100 cycles, 0 for 100, 0010 for 100, 0 for 100, then db_estado=2 with rodada=0.
- leds=0011 for one cycle -> erro_captura=1, rodada unchanged. Seventeen one-hot moves with DEPTH=16 -> rodada=16, erro_captura=1.
- perdeu asserted during PRESS -> next edge botoes=0, terminou=1. Then ativar=0 -> IDLE.
- Full 16-round game against `jogo_desafio_memoria` with the sequence 0001,0010,0100,1000,... -> ganhou=1, terminou=1. With JOGADOR_ERRO_EN, erro_en=1 and erro_idx=1 -> perdeu=1 in round 2.
